// File: rtl/fp_to_int_final_if.sv
// Start/ready/busy handshake bundle for the float-to-int32 converter.
interface fp_to_int_final_if;
   logic        start;
   logic [31:0] A;
   logic        ready;
   logic        busy;
   logic [31:0] Y;
   logic        invalid;
   logic        inexact;

   modport master (output start, A, input ready, busy, Y, invalid, inexact);
   modport slave  (input start, A, output ready, busy, Y, invalid, inexact);
endinterface

// File: rtl/fp_to_int_final.sv
// IEEE-754 single to int32 converter, round-to-nearest-even, saturating.
// The significand is aligned one bit per clock, so latency tracks the exponent.
module fp_to_int_final (
   input logic             clk,
   input logic             rst_n,
   fp_to_int_final_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CHECK, SHIFT, ROUND} state_t;

   state_t      state;
   logic [31:0] a_q;
   logic [31:0] mag;
   logic        guard;
   logic        sticky;
   logic        left;
   logic [4:0]  n;

   logic        sgn;
   logic [7:0]  ex;
   logic [22:0] frac;
   logic [31:0] sat_y;
   logic [31:0] mag_rnd;
   logic [7:0]  shamt;

   assign sgn   = a_q[31];
   assign ex    = a_q[30:23];
   assign frac  = a_q[22:0];
   assign sat_y = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
   // Unbiased exponent minus 23 is ex-150; its magnitude is the shift count.
   assign shamt   = (ex >= 8'd150) ? (ex - 8'd150) : (8'd150 - ex);
   assign mag_rnd = mag + {31'd0, guard & (sticky | mag[0])};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         bus.ready   <= 1'b0;
         bus.busy    <= 1'b0;
         bus.Y       <= 32'd0;
         bus.invalid <= 1'b0;
         bus.inexact <= 1'b0;
         a_q         <= 32'd0;
         mag         <= 32'd0;
         guard       <= 1'b0;
         sticky      <= 1'b0;
         left        <= 1'b0;
         n           <= 5'd0;
      end else begin
         bus.ready <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_q      <= bus.A;
                  bus.busy <= 1'b1;
                  state    <= CHECK;
               end
            end
            CHECK: begin
               if (ex == 8'hFF && frac != 23'd0) begin
                  bus.Y       <= 32'h7FFF_FFFF;
                  bus.invalid <= 1'b1;
                  bus.inexact <= 1'b0;
                  bus.ready   <= 1'b1;
                  bus.busy    <= 1'b0;
                  state       <= IDLE;
               end else if (ex == 8'hFF || (ex >= 8'd158 && a_q != 32'hCF00_0000)) begin
                  bus.Y       <= sat_y;
                  bus.invalid <= 1'b1;
                  bus.inexact <= 1'b0;
                  bus.ready   <= 1'b1;
                  bus.busy    <= 1'b0;
                  state       <= IDLE;
               end else if (a_q == 32'hCF00_0000) begin
                  bus.Y       <= 32'h8000_0000;
                  bus.invalid <= 1'b0;
                  bus.inexact <= 1'b0;
                  bus.ready   <= 1'b1;
                  bus.busy    <= 1'b0;
                  state       <= IDLE;
               end else if (ex < 8'd126) begin
                  bus.Y       <= 32'd0;
                  bus.invalid <= 1'b0;
                  bus.inexact <= |a_q[30:0];
                  bus.ready   <= 1'b1;
                  bus.busy    <= 1'b0;
                  state       <= IDLE;
               end else begin
                  mag    <= {8'd0, 1'b1, frac};
                  guard  <= 1'b0;
                  sticky <= 1'b0;
                  left   <= (ex > 8'd150);
                  n      <= shamt[4:0];
                  state  <= (shamt == 8'd0) ? ROUND : SHIFT;
               end
            end
            SHIFT: begin
               if (left) begin
                  mag <= mag << 1;
               end else begin
                  sticky <= sticky | guard;
                  guard  <= mag[0];
                  mag    <= mag >> 1;
               end
               n <= n - 5'd1;
               if (n == 5'd1) state <= ROUND;
            end
            ROUND: begin
               // mag_rnd stays below 2^31 for every exponent reaching here.
               bus.Y       <= sgn ? (32'd0 - mag_rnd) : mag_rnd;
               bus.invalid <= 1'b0;
               bus.inexact <= guard | sticky;
               bus.ready   <= 1'b1;
               bus.busy    <= 1'b0;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_to_int_final.sv
// Randomised and directed bench for fp_to_int_final against an arithmetic RNE model.
module tb_fp_to_int_final;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   fp_to_int_final_if bus ();

   fp_to_int_final dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: value = mant * 2^k evaluated with integer arithmetic, then range-checked.
   function automatic void model(input logic [31:0] a, output logic [31:0] y,
                                 output logic inv, output logic inex, output int lat);
      logic       s;
      int         e8, k, kk;
      logic [22:0] f;
      longint     mant, q, rem, half, mag, v;
      logic       up;
      s  = a[31];
      e8 = int'(a[30:23]);
      f  = a[22:0];
      lat = (e8 == 255 || e8 >= 158 || e8 < 126) ? 1 : ((e8 >= 150) ? e8 - 150 : 150 - e8) + 2;
      inv = 1'b0; inex = 1'b0; y = 32'd0;
      if (e8 == 255) begin
         inv = 1'b1;
         y = (f != 0) ? 32'h7FFF_FFFF : (s ? 32'h8000_0000 : 32'h7FFF_FFFF);
         return;
      end
      if (e8 >= 190) begin
         inv = 1'b1;
         y = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
         return;
      end
      mant = (e8 == 0) ? longint'(f) : (longint'(f) + (64'sd1 <<< 23));
      k = (e8 == 0) ? -149 : e8 - 150;
      rem = 0; up = 1'b0;
      if (k >= 0) begin
         q = mant <<< k;
      end else begin
         kk = -k;
         if (kk > 40) begin
            q = 0; rem = mant;
         end else begin
            q    = mant >>> kk;
            rem  = mant - (q <<< kk);
            half = 64'sd1 <<< (kk - 1);
            up   = (rem > half) || (rem == half && q[0]);
         end
      end
      mag = q + (up ? 64'sd1 : 64'sd0);
      v = s ? -mag : mag;
      if (v > 64'sd2147483647 || v < -64'sd2147483648) begin
         inv = 1'b1;
         y = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
         y = v[31:0];
         inex = (rem != 0);
      end
   endfunction

   // Issues one conversion and waits (bounded) for ready; lat counts edges after the sampling edge.
   task automatic run_conv(input logic [31:0] a, output logic [31:0] y, output logic inv,
                           output logic inex, output int lat, output logic busy_ok);
      bus.start = 1'b1;
      bus.A = a;
      @(posedge clk);
      #1 bus.start = 1'b0;
      lat = 0;
      busy_ok = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.ready) begin
            if (bus.busy) busy_ok = 1'b0;
            break;
         end
         if (!bus.busy) busy_ok = 1'b0;
      end
      y = bus.Y; inv = bus.invalid; inex = bus.inexact;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.A = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.Y !== 32'd0) begin failures++; $display("FAIL reset_Y got=%h exp=0", bus.Y); end
      checks++; if (bus.invalid !== 1'b0 || bus.inexact !== 1'b0) begin
         failures++; $display("FAIL reset_flags got=%b%b exp=00", bus.invalid, bus.inexact); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_directed();
      logic [31:0] da [13] = '{32'h3F80_0000, 32'h4020_0000, 32'h4060_0000, 32'h3F40_0000,
                               32'h3F00_0000, 32'hC2F6_0000, 32'h4EFF_FFFF, 32'h4F00_0000,
                               32'hCF00_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h0000_0001,
                               32'h8000_0000};
      logic [31:0] dy [13] = '{32'h1, 32'h2, 32'h4, 32'h1, 32'h0, 32'hFFFF_FF85, 32'h7FFF_FF80,
                               32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000,
                               32'h0, 32'h0};
      logic        dv [13] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0};
      logic        dx [13] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0};
      int          dl [13] = '{25, 24, 24, 26, 26, 19, 9, 1, 1, 1, 1, 1, 1};
      logic [31:0] y;
      logic        inv, inex, bok;
      int          lat;
      for (int i = 0; i < 13; i++) begin
         run_conv(da[i], y, inv, inex, lat, bok);
         checks++; if (y !== dy[i] || inv !== dv[i] || inex !== dx[i]) begin
            failures++;
            $display("FAIL directed_result A=%h got Y=%h inv=%b inex=%b exp Y=%h inv=%b inex=%b",
                     da[i], y, inv, inex, dy[i], dv[i], dx[i]);
         end
         checks++; if (lat != dl[i] || !bok) begin
            failures++; $display("FAIL directed_latency A=%h got L=%0d busy_ok=%b exp L=%0d", da[i], lat, bok, dl[i]);
         end
         @(posedge clk);
         #1;
         checks++; if (bus.ready !== 1'b0 || bus.Y !== dy[i]) begin
            failures++; $display("FAIL directed_hold A=%h got ready=%b Y=%h exp ready=0 Y=%h", da[i], bus.ready, bus.Y, dy[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a, y, ey;
      logic        inv, inex, einv, einex, bok;
      int          lat, elat, pos;
      for (int i = 0; i < 240; i++) begin
         a = $urandom;
         case (i % 4)
            1, 2: a[30:23] = 8'($urandom_range(120, 165));
            3: begin
               pos = $urandom_range(0, 22);
               a[22:0] = 23'(($urandom << (pos + 1)) | (32'd1 << pos));
               a[30:23] = 8'(150 - (pos + 1));
            end
            default: ;
         endcase
         model(a, ey, einv, einex, elat);
         run_conv(a, y, inv, inex, lat, bok);
         checks++; if (y !== ey || inv !== einv || inex !== einex || lat != elat || !bok) begin
            failures++;
            $display("FAIL random A=%h got Y=%h inv=%b inex=%b L=%0d bok=%b exp Y=%h inv=%b inex=%b L=%0d",
                     a, y, inv, inex, lat, bok, ey, einv, einex, elat);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] al [3] = '{32'h4EFF_FFFF, 32'hC2F6_0000, 32'h3F40_0000};
      logic [31:0] y, ey;
      logic        inv, inex, einv, einex, bok;
      int          lat, elat;
      // Each call raises start in the cycle where the previous ready is still high.
      for (int i = 0; i < 3; i++) begin
         model(al[i], ey, einv, einex, elat);
         run_conv(al[i], y, inv, inex, lat, bok);
         checks++; if (y !== ey || inex !== einex || lat != elat) begin
            failures++; $display("FAIL back_to_back A=%h got Y=%h inex=%b L=%0d exp Y=%h inex=%b L=%0d",
                                 al[i], y, inex, lat, ey, einex, elat);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_busy_ignore();
      int lat = 0;
      int extra = 0;
      bus.start = 1'b1;
      bus.A = 32'h3F80_0000;
      @(posedge clk);
      #1 bus.start = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (c == 3) begin bus.start = 1'b1; bus.A = 32'h4060_0000; end
         if (c == 5) bus.start = 1'b0;
         @(posedge clk);
         #1;
         lat++;
         if (bus.ready) break;
      end
      bus.start = 1'b0;
      checks++; if (bus.Y !== 32'd1 || lat != 25) begin
         failures++; $display("FAIL busy_ignore got Y=%h L=%0d exp Y=00000001 L=25", bus.Y, lat);
      end
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (bus.ready) extra++;
      end
      checks++; if (extra != 0) begin
         failures++; $display("FAIL busy_ignore_extra got ready_pulses=%0d exp 0", extra);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] y;
      logic        inv, inex, bok;
      int          lat;
      int          seen = 0;
      bus.start = 1'b1;
      bus.A = 32'h3F40_0000;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      checks++; if (bus.Y !== 32'd0 || bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.inexact !== 1'b0) begin
         failures++; $display("FAIL reset_mid_outputs got Y=%h busy=%b ready=%b inex=%b exp all 0",
                              bus.Y, bus.busy, bus.ready, bus.inexact);
      end
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (bus.ready || bus.busy) seen++;
      end
      checks++; if (seen != 0) begin
         failures++; $display("FAIL reset_mid_quiet got active_cycles=%0d exp 0", seen);
      end
      run_conv(32'h4020_0000, y, inv, inex, lat, bok);
      checks++; if (y !== 32'd2 || inex !== 1'b1 || inv !== 1'b0 || lat != 24) begin
         failures++; $display("FAIL reset_mid_fresh got Y=%h inex=%b inv=%b L=%0d exp Y=00000002 inex=1 inv=0 L=24",
                              y, inex, inv, lat);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_busy_ignore();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
